// File: rtl/mul_iter_ctrl.sv
// Iterative RV32M multiplier sequencer: sign handling, RADIX-bit shift-add steps, final negate
// and high/low word select, with valid/ready handshakes on both sides.
module mul_iter_ctrl #(
    parameter int RADIX      = 2,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        busy_o
);

    // state | meaning
    // IDLE  | waiting for an op, in_ready_o high
    // PREP  | operand signs and magnitudes, accumulator/counter init
    // ITER  | one shift-add step per cycle, RADIX multiplier bits each
    // FIX   | conditional 64-bit negate and result word select
    // DONE  | result presented until writeback accepts it
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    localparam int         ITERS    = 32 / RADIX;
    localparam logic [4:0] CNT_LOAD = 5'(ITERS - 1);

    state_t      state_q, state_d;
    logic [1:0]  funct3_q;
    logic [31:0] rs1_q, rs2_q;
    logic [31:0] mcand_q;
    logic [31:0] hi_q, lo_q;
    logic        neg_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;

    logic        sign1, sign2;
    logic [31:0] mag_a, mag_b;
    logic        zero_skip;
    logic [33:0] pp0, pp1, step_sum;
    logic [31:0] hi_step, lo_step;
    logic [63:0] product, fixed;
    logic        accept;

    assign accept = in_valid_i && !flush_i && (state_q == IDLE);

    // Magnitude stays in 32 unsigned bits, so -2^31 maps to 2^31 without overflow.
    assign sign1     = ((funct3_q == 2'b01) || (funct3_q == 2'b10)) && rs1_q[31];
    assign sign2     = (funct3_q == 2'b01) && rs2_q[31];
    assign mag_a     = sign1 ? (32'd0 - rs1_q) : rs1_q;
    assign mag_b     = sign2 ? (32'd0 - rs2_q) : rs2_q;
    assign zero_skip = EARLY_ZERO && ((mag_a == 32'd0) || (mag_b == 32'd0));

    // 34-bit step sum: the 2-bit carry-out lands in the top of the new high word.
    assign pp0      = lo_q[0] ? {2'b00, mcand_q} : 34'd0;
    assign pp1      = ((RADIX == 2) && lo_q[1]) ? {1'b0, mcand_q, 1'b0} : 34'd0;
    assign step_sum = {2'b00, hi_q} + pp0 + pp1;
    assign hi_step  = step_sum[RADIX+31:RADIX];
    assign lo_step  = {step_sum[RADIX-1:0], lo_q[31:RADIX]};

    assign product = {hi_q, lo_q};
    assign fixed   = neg_q ? (64'd0 - product) : product;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = PREP;
            // Zero operands pass through FIX with a cleared accumulator, giving 0 in two cycles.
            PREP: state_d = zero_skip ? FIX : ITER;
            ITER: if (cnt_q == 5'd0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            funct3_q <= 2'b00;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            mcand_q  <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            neg_q    <= 1'b0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= funct3_i;
                        rs1_q    <= rs1_i;
                        rs2_q    <= rs2_i;
                    end
                end
                PREP: begin
                    mcand_q <= mag_a;
                    hi_q    <= 32'd0;
                    lo_q    <= zero_skip ? 32'd0 : mag_b;
                    neg_q   <= sign1 ^ sign2;
                    cnt_q   <= CNT_LOAD;
                end
                ITER: begin
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q - 5'd1;
                end
                FIX: begin
                    if (!flush_i)
                        result_q <= (funct3_q == 2'b00) ? fixed[31:0] : fixed[63:32];
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// Directed bench for mul_iter_ctrl: hand-computed products, latencies, backpressure,
// flush and asynchronous reset, plus a short run against a 64-bit reference product.
module tb_mul_iter_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    mul_iter_ctrl #(.RADIX(2), .EARLY_ZERO(1'b1)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .funct3_i    (funct3_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one op, measures accept-to-valid latency, checks result, then completes the handshake.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk_i);
        funct3_i   = f;
        rs1_i      = a;
        rs2_i      = b;
        in_valid_i = 1'b1;
        check({tag, "_ready"}, {31'd0, in_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp);
        @(negedge clk_i);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check({tag, "_idle"}, {30'd0, out_valid_o, in_ready_o}, 32'd1);
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        sb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = sa * sb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    initial begin
        logic [31:0] corner [4];
        logic [31:0] held;
        logic        seen;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;

        rst_n_i = 1'b0; in_valid_i = 1'b0; funct3_i = 2'b00; rs1_i = '0; rs2_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b0;
        #1;
        check("rst_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_busy",  {31'd0, busy_o}, 32'd0);
        check("rst_res",   result_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        run_op("mul_7x6",      2'b00, 32'd7,         32'd6,         32'h0000_002A, 18);
        run_op("mulh_min2",    2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18);
        run_op("mulh_m1m1",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 18);
        run_op("mulhsu_m1",    2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18);
        run_op("mulhu_max",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 18);
        run_op("mul_m1m1",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 18);
        run_op("mul_3xm2",     2'b00, 32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFA, 18);
        run_op("mulh_3xm2",    2'b01, 32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 18);
        run_op("mulh_minx1",   2'b01, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 18);
        run_op("mulhu_2p32",   2'b11, 32'h8000_0000, 32'd2,         32'h0000_0001, 18);
        run_op("mulhsu_2xmin", 2'b10, 32'd2,         32'h8000_0000, 32'h0000_0001, 18);
        run_op("mul_hex",      2'b00, 32'h1234_5678, 32'h10,        32'h2345_6780, 18);
        run_op("mul_zero",     2'b00, 32'd0,         32'h1234_5678, 32'h0000_0000, 2);
        run_op("mulh_zero_b",  2'b01, 32'hDEAD_BEEF, 32'd0,         32'h0000_0000, 2);

        // Backpressure: result and flags hold while writeback stalls; new requests are ignored.
        @(negedge clk_i);
        funct3_i = 2'b00; rs1_i = 32'd100; rs2_i = 32'd25; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk_i);
            #1;
            seen = out_valid_o;
        end
        check("hold_valid", {31'd0, seen}, 32'd1);
        held = result_o;
        check("hold_res0", held, 32'd2500);
        repeat (5) @(posedge clk_i);
        #1;
        check("hold_res5",   result_o, 32'd2500);
        check("hold_vld5",   {31'd0, out_valid_o}, 32'd1);
        check("hold_ready5", {31'd0, in_ready_o}, 32'd0);
        @(negedge clk_i);
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check("hold_done", {30'd0, busy_o, in_ready_o}, 32'd1);

        // Flush on the fifth ITER cycle.
        @(negedge clk_i);
        funct3_i = 2'b11; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'h7; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check("flush_busy_pre", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_idle", {30'd0, busy_o, in_ready_o}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o) seen = 1'b1;
        end
        check("flush_no_out", {31'd0, seen}, 32'd0);

        // Flush beats a simultaneous request in IDLE.
        @(negedge clk_i);
        in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        check("flush_idle_req", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset mid-ITER.
        @(negedge clk_i);
        funct3_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd9; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_ready", {31'd0, in_ready_o}, 32'd1);
        check("arst_busy",  {31'd0, busy_o}, 32'd0);
        check("arst_valid", {31'd0, out_valid_o}, 32'd0);
        check("arst_res",   result_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o) seen = 1'b1;
        end
        check("arst_no_out", {31'd0, seen}, 32'd0);
        run_op("post_rst", 2'b00, 32'd9, 32'd9, 32'd81, 18);

        for (int k = 0; k < 60; k++) begin
            logic [1:0]  f;
            logic [31:0] a, b;
            f = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            run_op("rnd", f, a, b, ref_mul(f, a, b), (a == 32'd0 || b == 32'd0) ? 2 : 18);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
